ntt_addr_scheduler: RTL and testbench
=====================================

Name: ntt_addr_scheduler

Overview:
Sequences an in-place iterative radix-2 NTT over N = 2^LOGN coefficients held in a dual-port coefficient RAM. Each cycle it issues one butterfly, giving read addresses and a twiddle index to the butterfly datapath, whose pipeline is built from master_slave_dff registers. It delays the same addresses by the datapath latency to drive write-back. It inserts drain bubbles between stages so that no read-after-write hazard can occur.

Parameters:
LOGN, 3, log2 of transform size N (N = 8 by default); legal range 2..12
PIPE_LAT, 2, butterfly datapath latency in cycles from read issue to write-back; legal range 1..8

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin transform; sampled only in IDLE
hold  input  1  suppress butterfly issue this cycle; the write-back delay line keeps advancing
busy  output  1  high in ISSUE and DRAIN
done  output  1  single-cycle pulse in DONE state
stage  output  LOGN  current stage index s, 0..LOGN-1
rd_valid  output  1  butterfly issued this cycle
rd_addr_a  output  LOGN  upper butterfly operand address
rd_addr_b  output  LOGN  lower butterfly operand address
tw_idx  output  LOGN-1  twiddle ROM index
wr_valid  output  1  rd_valid delayed PIPE_LAT cycles
wr_addr_a  output  LOGN  rd_addr_a delayed PIPE_LAT cycles
wr_addr_b  output  LOGN  rd_addr_b delayed PIPE_LAT cycles

Behaviour:
- Reset (rst=0, asynchronous) applies to every output and state register:
  - State goes to IDLE.
  - stage and the butterfly counter clear to 0; the drain counter clears.
  - All delay-line entries are cleared, so wr_valid=0.
  - Every output reads 0.
- Reset asserted mid-transform aborts it. No wr_valid is produced after reset release.
- State machine (registered state):
  - IDLE: if start=1, go to ISSUE with stage=0 and b=0. Otherwise stay in IDLE.
  - ISSUE:
    - If hold=1, rd_valid=0 and counters do not change.
    - If hold=0, rd_valid=1 and b increments.
    - When b = N/2-1 is issued, go to DRAIN and load the drain counter with PIPE_LAT.
  - DRAIN: rd_valid=0. The counter decrements each cycle; hold has no effect.
    - When the counter reaches 1 and stage < LOGN-1: stage increments, b=0, go to ISSUE.
    - When the counter reaches 1 and stage = LOGN-1: go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- start while busy or in DONE is ignored.
- Address generation is combinational from the registered b and s (half = 2^s):
  - k = b mod half; grp = b >> s.
  - rd_addr_a = (grp << (s+1)) | k.
  - rd_addr_b = rd_addr_a + half.
  - tw_idx = k << (LOGN-1-s).
  - All widths are truncated to the port width; no overflow is possible in legal ranges.
- rd_addr_* and tw_idx are driven 0 whenever rd_valid=0.
- The write-back path is a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}. It advances every cycle regardless of state or hold.
- Hazard rule: the first read of stage s+1 occurs at least one cycle after the last write of stage s becomes visible.
- Cycle count with hold=0:
  - start is sampled at cycle −1 and the first issue is at cycle 0.
  - done is asserted at cycle LOGN·(N/2 + PIPE_LAT).
- Each asserted hold cycle delays all later events by exactly one cycle.

Test Plan:
- Defaults, hold=0, start at cycle −1:
  - Stage 0 issues (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0) at cycles 0–3.
  - rd_valid=0 at cycles 4–5.
  - Stage 1 issues (0,2,0), (1,3,2), (4,6,0), (5,7,2) at cycles 6–9.
  - Stage 2 issues (0,4,0), (1,5,1), (2,6,2), (3,7,3) at cycles 12–15.
  - done=1 only at cycle 18; busy=1 at cycles 0–17.
- Write-back tracking:
  - wr_valid/wr_addr_* equal rd_valid/rd_addr_* delayed exactly 2 cycles.
  - Last write at cycle 17 is (3,7).
  - No write is ever issued to an address in the same cycle it is read in a later stage.
- hold=1 during cycles 1–2:
  - The second butterfly (2,3) issues at cycle 3.
  - done moves to cycle 20.
  - hold asserted during DRAIN changes nothing.
- start pulsed again at cycles 5 and 18 during a transform:
  - Ignored; done appears only once.
  - A new start at cycle 19 (IDLE) begins a fresh transform at cycle 20.
- rst driven low asynchronously mid-cycle during stage 1:
  - All outputs go 0 immediately.
  - After release with no start: no rd_valid, wr_valid, or done for 30 cycles.
- LOGN=4, PIPE_LAT=1:
  - 4 stages × 9 cycles; done at cycle 36.
  - Stage 3 issues (k, k+8, tw=k) for k=0..7.

Source files
------------

// File: rtl/ntt_addr_scheduler.sv
// Address/twiddle sequencer for an in-place radix-2 NTT: one butterfly per cycle,
// drain bubbles between stages, and a write-back delay line matching the datapath latency.
module ntt_addr_scheduler #(
  parameter int LOGN     = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_valid,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic            wr_valid,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int              BW         = LOGN - 1;
  localparam int              CW         = 4;
  localparam logic [BW-1:0]   B_LAST     = '1;
  localparam logic [CW-1:0]   DRAIN_INIT = CW'(PIPE_LAT);
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [BW-1:0]   b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [PIPE_LAT-1:0] dv_q, dv_d;
  logic [LOGN-1:0]     da_q [PIPE_LAT];
  logic [LOGN-1:0]     da_d [PIPE_LAT];
  logic [LOGN-1:0]     db_q [PIPE_LAT];
  logic [LOGN-1:0]     db_d [PIPE_LAT];

  logic [LOGN-1:0] b_ext, half, k, grp, addr_a, tw_full;

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    rd_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          b_d     = '0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (!hold) begin
          rd_valid = 1'b1;
          b_d      = b_q + BW'(1);
          if (b_q == B_LAST) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        // Leaving at count 1 keeps the next stage's first read one cycle past the last write.
        if (cnt_q == CW'(1)) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + LOGN'(1);
            b_d     = '0;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    b_ext   = LOGN'(b_q);
    half    = LOGN'(1) << stage_q;
    k       = b_ext & (half - LOGN'(1));
    grp     = b_ext >> stage_q;
    addr_a  = (grp << (stage_q + LOGN'(1))) | k;
    tw_full = k << (STAGE_LAST - stage_q);
  end

  assign rd_addr_a = rd_valid ? addr_a : '0;
  assign rd_addr_b = rd_valid ? (addr_a + half) : '0;
  assign tw_idx    = rd_valid ? tw_full[LOGN-2:0] : '0;
  assign stage     = stage_q;

  always_comb begin
    dv_d[0] = rd_valid;
    da_d[0] = rd_addr_a;
    db_d[0] = rd_addr_b;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dv_d[i] = dv_q[i-1];
      da_d[i] = da_q[i-1];
      db_d[i] = db_q[i-1];
    end
  end

  assign wr_valid  = dv_q[PIPE_LAT-1];
  assign wr_addr_a = da_q[PIPE_LAT-1];
  assign wr_addr_b = db_q[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dv_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        da_q[i] <= '0;
        db_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        da_q[i] <= da_d[i];
        db_q[i] <= db_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ntt_addr_scheduler.sv
// Directed bench for ntt_addr_scheduler: default N=8/latency-2 instance plus an N=16/latency-1 instance.
module tb_ntt_addr_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, hold = 1'b0;
  logic       busy, done, rd_valid, wr_valid;
  logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx;

  logic       start4 = 1'b0, hold4 = 1'b0;
  logic       busy4, done4, rd_valid4, wr_valid4;
  logic [3:0] stage4, rd_addr_a4, rd_addr_b4, wr_addr_a4, wr_addr_b4;
  logic [2:0] tw_idx4;

  ntt_addr_scheduler u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
    .stage(stage), .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .wr_valid(wr_valid), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  ntt_addr_scheduler #(.LOGN(4), .PIPE_LAT(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .hold(hold4), .busy(busy4), .done(done4),
    .stage(stage4), .rd_valid(rd_valid4), .rd_addr_a(rd_addr_a4), .rd_addr_b(rd_addr_b4),
    .tw_idx(tw_idx4), .wr_valid(wr_valid4), .wr_addr_a(wr_addr_a4), .wr_addr_b(wr_addr_b4)
  );

  int checks = 0;
  int failures = 0;

  // Hand-derived schedule for N=8, PIPE_LAT=2, no hold, cycles 0..19.
  int exp_rv [20] = '{1,1,1,1, 0,0, 1,1,1,1, 0,0, 1,1,1,1, 0,0, 0,0};
  int exp_a  [20] = '{0,2,4,6, 0,0, 0,1,4,5, 0,0, 0,1,2,3, 0,0, 0,0};
  int exp_b  [20] = '{1,3,5,7, 0,0, 2,3,6,7, 0,0, 4,5,6,7, 0,0, 0,0};
  int exp_tw [20] = '{0,0,0,0, 0,0, 0,2,0,2, 0,0, 0,1,2,3, 0,0, 0,0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_a", rd_addr_a, 0);
    chk("rst_wr_b", wr_addr_b, 0);
    chk("rst_busy4", busy4, 0);
    #3 rst = 1'b1;
    tick();
    tick();

    // Nominal transform, no hold
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 20; t++) begin
      chk($sformatf("t1_rv_c%0d", t), rd_valid, exp_rv[t]);
      chk($sformatf("t1_a_c%0d", t), rd_addr_a, exp_a[t]);
      chk($sformatf("t1_b_c%0d", t), rd_addr_b, exp_b[t]);
      chk($sformatf("t1_tw_c%0d", t), tw_idx, exp_tw[t]);
      chk($sformatf("t1_done_c%0d", t), done, (t == 18));
      chk($sformatf("t1_busy_c%0d", t), busy, (t < 18));
      if (t < 18) chk($sformatf("t1_stage_c%0d", t), stage, t / 6);
      if (t >= 2) begin
        chk($sformatf("t1_wv_c%0d", t), wr_valid, exp_rv[t-2]);
        chk($sformatf("t1_wa_c%0d", t), wr_addr_a, exp_a[t-2]);
        chk($sformatf("t1_wb_c%0d", t), wr_addr_b, exp_b[t-2]);
      end else begin
        chk($sformatf("t1_wv_c%0d", t), wr_valid, 0);
      end
      if (rd_valid && wr_valid)
        chk($sformatf("t1_hazard_c%0d", t),
            (wr_addr_a == rd_addr_a) || (wr_addr_a == rd_addr_b) ||
            (wr_addr_b == rd_addr_a) || (wr_addr_b == rd_addr_b), 0);
      if (t == 17) begin
        chk("t1_lastwr_a", wr_addr_a, 3);
        chk("t1_lastwr_b", wr_addr_b, 7);
      end
      tick();
    end

    // Hold during issue (cycles 1-2) and during drain (cycles 6-7)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 22; t++) begin
      hold = (t == 1 || t == 2 || t == 6 || t == 7);
      #1;
      if (t == 0) begin
        chk("t2_a_c0", rd_addr_a, 0);
        chk("t2_b_c0", rd_addr_b, 1);
      end
      if (t == 1 || t == 2) chk($sformatf("t2_rv_hold_c%0d", t), rd_valid, 0);
      if (t == 3) begin
        chk("t2_rv_c3", rd_valid, 1);
        chk("t2_a_c3", rd_addr_a, 2);
        chk("t2_b_c3", rd_addr_b, 3);
      end
      if (t == 8) begin
        chk("t2_rv_c8", rd_valid, 1);
        chk("t2_stage_c8", stage, 1);
        chk("t2_b_c8", rd_addr_b, 2);
      end
      chk($sformatf("t2_done_c%0d", t), done, (t == 20));
      tick();
    end
    hold = 1'b0;

    // Start ignored while busy/DONE, restart from IDLE, then async reset mid stage 1
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 28; t++) begin
      start = (t == 5 || t == 18 || t == 19);
      chk($sformatf("t3_done_c%0d", t), done, (t == 18));
      if (t == 19) chk("t3_busy_c19", busy, 0);
      if (t == 20) begin
        chk("t3_rv_c20", rd_valid, 1);
        chk("t3_a_c20", rd_addr_a, 0);
        chk("t3_b_c20", rd_addr_b, 1);
        chk("t3_busy_c20", busy, 1);
      end
      if (t < 27) tick();
    end
    start = 1'b0;
    chk("t3_stage_c27", stage, 1);
    chk("t3_a_c27", rd_addr_a, 1);
    chk("t3_b_c27", rd_addr_b, 3);
    #3 rst = 1'b0;
    #1;
    chk("t4_rv", rd_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_stage", stage, 0);
    chk("t4_a", rd_addr_a, 0);
    chk("t4_b", rd_addr_b, 0);
    chk("t4_tw", tw_idx, 0);
    chk("t4_wv", wr_valid, 0);
    chk("t4_wa", wr_addr_a, 0);
    chk("t4_wb", wr_addr_b, 0);
    chk("t4_done", done, 0);
    tick();
    #3 rst = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      chk($sformatf("t4_quiet_c%0d", t), {rd_valid, wr_valid, done, busy}, 0);
    end

    // N=16, PIPE_LAT=1 instance
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int t = 0; t < 38; t++) begin
      chk($sformatf("t5_done_c%0d", t), done4, (t == 36));
      if (t == 35) chk("t5_busy_c35", busy4, 1);
      if (t == 36) chk("t5_busy_c36", busy4, 0);
      if (t >= 27 && t <= 34) begin
        chk($sformatf("t5_rv_c%0d", t), rd_valid4, 1);
        chk($sformatf("t5_stage_c%0d", t), stage4, 3);
        chk($sformatf("t5_a_c%0d", t), rd_addr_a4, t - 27);
        chk($sformatf("t5_b_c%0d", t), rd_addr_b4, t - 27 + 8);
        chk($sformatf("t5_tw_c%0d", t), tw_idx4, t - 27);
      end
      if (t >= 28 && t <= 35) begin
        chk($sformatf("t5_wv_c%0d", t), wr_valid4, 1);
        chk($sformatf("t5_wa_c%0d", t), wr_addr_a4, t - 28);
        chk($sformatf("t5_wb_c%0d", t), wr_addr_b4, t - 28 + 8);
      end
      if (t == 8 || t == 17 || t == 26) chk($sformatf("t5_bubble_c%0d", t), rd_valid4, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
